// File: rtl/gray_pkg.sv
// Shared types and helpers for the RGB frame fetch and gray conversion path.
package gray_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_R,
    RD_G,
    RD_B,
    CAP,
    PRESENT,
    FIN
  } fetch_state_t;

  // Pixels per colour plane; also the spacing between plane base addresses.
  function automatic int npix(input int row, input int col);
    return row * col;
  endfunction

endpackage

// File: rtl/rgb_plane_fetch_ctrl.sv
// Walks a planar R/G/B frame buffer through one shared byte memory and
// presents each assembled pixel to the gray converter over valid/ready.
module rgb_plane_fetch_ctrl
  import gray_pkg::*;
#(
  parameter int ROW = 1153,
  parameter int COL = 2048,
  localparam int NPIX = npix(ROW, COL),
  localparam int PIX_W = $clog2(NPIX),
  localparam int ADDR_W = $clog2(3 * NPIX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_red,
  output logic [7:0]        pix_green,
  output logic [7:0]        pix_blue,
  output logic [PIX_W-1:0]  pix_index,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] OFF_G    = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] OFF_B    = ADDR_W'(2 * NPIX);
  localparam logic [PIX_W-1:0]  LAST_IDX = PIX_W'(NPIX - 1);

  fetch_state_t state;
  logic [PIX_W-1:0]  idx;
  logic [ADDR_W-1:0] idx_ext;

  // Plane offsets are constant adds on the zero-extended index.
  assign idx_ext   = ADDR_W'(idx);
  assign pix_index = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      pix_valid <= 1'b0;
      pix_red   <= 8'd0;
      pix_green <= 8'd0;
      pix_blue  <= 8'd0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= '0;
            busy     <= 1'b1;
            state    <= RD_R;
          end
        end
        RD_R: begin
          mem_addr <= idx_ext + OFF_G;
          state    <= RD_G;
        end
        RD_G: begin
          // Data for the read issued last cycle arrives now.
          pix_red  <= mem_rdata;
          mem_addr <= idx_ext + OFF_B;
          state    <= RD_B;
        end
        RD_B: begin
          pix_green <= mem_rdata;
          mem_rd    <= 1'b0;
          mem_addr  <= '0;
          state     <= CAP;
        end
        CAP: begin
          pix_blue  <= mem_rdata;
          pix_valid <= 1'b1;
          pix_last  <= (idx == LAST_IDX);
          state     <= PRESENT;
        end
        PRESENT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (pix_last) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx      <= idx + PIX_W'(1);
              mem_rd   <= 1'b1;
              mem_addr <= idx_ext + ADDR_W'(1);
              state    <= RD_R;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_rd_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(pix_valid && mem_rd));

  a_done_after_last: assert property (@(posedge clk) disable iff (rst)
    done |-> ($past(state) == PRESENT && $past(pix_last)));

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    32'(idx) < NPIX);

endmodule

// File: doc/rgb_plane_fetch_ctrl.md
# rgb_plane_fetch_ctrl

Sequencer that walks a planar RGB frame buffer and feeds the grayscale converter one pixel at a time. The frame buffer stores the red, green and blue planes back to back. One single-port byte memory holds all three planes and is time-shared across them, so the block fetches each pixel's three bytes over three consecutive reads. It then presents the assembled pixel with a valid/ready handshake and pulses `done` after the last pixel. It sits between the frame-buffer memory and the RGB-to-gray datapath, and replaces free-running pixel counters.

## Interface
Parameters:
- `ROW`, 1153, image rows
- `COL`, 2048, image columns
- `NPIX`, ROW*COL (derived, localparam), pixels per plane
- `PIX_W`, $clog2(NPIX) (derived), pixel index width; 22 at defaults
- `ADDR_W`, $clog2(3*NPIX) (derived), memory address width; 23 at defaults

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin frame; sampled in IDLE only
- `mem_rd`  out  1  read strobe to frame memory
- `mem_addr`  out  ADDR_W  byte address
- `mem_rdata`  in  8  read data, valid exactly one cycle after `mem_rd`
- `pix_valid`  out  1  pixel bytes valid
- `pix_ready`  in  1  converter accepts pixel
- `pix_red`, `pix_green`, `pix_blue`  out  8 each  pixel components
- `pix_index`  out  PIX_W  index of presented pixel
- `pix_last`  out  1  presented pixel is NPIX-1
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse after last pixel accepted

## Operation
- States: IDLE, RD_R, RD_G, RD_B, CAP, PRESENT, FIN.
- IDLE: if `start`, clear pixel index i to 0 and go to RD_R.
- RD_R: `mem_rd`=1, `mem_addr`=i. Go to RD_G.
- RD_G: `mem_rd`=1, `mem_addr`=i+NPIX. Capture `mem_rdata` into red. Go to RD_B.
- RD_B: `mem_rd`=1, `mem_addr`=i+2*NPIX. Capture green. Go to CAP.
- CAP: `mem_rd`=0. Capture blue. Go to PRESENT.
- PRESENT: `pix_valid`=1. Component registers, `pix_index`=i and `pix_last`=(i==NPIX-1) are held stable.
  - On `pix_ready`=1 with i==NPIX-1: go to FIN.
  - On `pix_ready`=1 otherwise: i←i+1, go to RD_R.
  - While `pix_ready`=0: stay.
- FIN: `done`=1 for this single cycle, then IDLE.
- Address arithmetic: the plane offsets are constant adds of i zero-extended to ADDR_W. No multiplier on i. Unsigned throughout.
- `start` is ignored in every state except IDLE, including FIN.
- `mem_addr` is 0 whenever `mem_rd`=0.
- `rst` asserted in any state goes to IDLE immediately. A pixel in flight is dropped, and the next `start` restarts at i=0.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `pix_valid`=0, `pix_red`/`pix_green`/`pix_blue`=0, `pix_index`=0, `pix_last`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `pix_ready` or `mem_rdata` to any output.
- Let `start` be sampled at edge t. Then `mem_rd` is high in cycles t+1..t+3 and `pix_valid` rises at t+5.
- Per-pixel cost is 5 cycles with `pix_ready` held at 1.
- A full frame with constant ready takes 5*NPIX+1 cycles from `start` to the `done` pulse. FIN is the cycle after the last handshake.
- `pix_valid` drops the cycle after the handshake. It never deasserts without a handshake except on reset.
- Wrap-around: i never exceeds NPIX-1, and there is no modulo wrap. If i ≥ NPIX were ever reached, that is a design error and is covered by an assertion.

## Structure
- Shared package `gray_pkg`: the state enum, and the plane offset constant function `npix(ROW,COL)`. The gray converter uses the same package.
- Single module. No sub-module is warranted. The index counter and address mux stay inline.
- Assertions:
  - `pix_valid` and `mem_rd` are never both high.
  - `done` implies the previous state was PRESENT with `pix_last`.

## Test plan
Small frame ROW=2, COL=3 (NPIX=6). Memory preloaded with byte[a]=a. Memory model has 1-cycle read latency.
- Constant ready → pixels 0..5 presented as (i, i+6, i+12). `pix_last` is high on index 5 only. `done` pulses once, 31 cycles after `start`.
- Reset behaviour → all outputs 0 and `busy`=0 after `rst`. `start` pulsed while busy mid-frame → no restart, and the index sequence is unchanged.
- Ready held low for 7 cycles on pixel 2 → `pix_valid`, components and `pix_index`=2 are stable throughout. `mem_rd` stays low and there is no advance.
- `rst` asserted during RD_G of pixel 3 → IDLE asynchronously, outputs return to reset values. A new `start` yields pixel 0 = (0, 6, 12).
- `start` held high continuously → back-to-back frames. One `done` per frame, and the index restarts at 0 after FIN→IDLE.
- Address trace check → the `mem_addr` sequence is exactly 0, 6, 12, 1, 7, 13, …, 5, 11, 17, with every read strobe one cycle apart within a pixel.
